// File: rtl/ras_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ras_ctrl_if : fetch, resolve, RAS and prediction bundle for ras_ctrl |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ras_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc;
  logic [31:0]      in_instr;
  logic             resolve_valid;
  logic             resolve_mispredict;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_branch;
  logic             ras_close_valid;
  logic             ras_close_invalid;
  logic [WIDTH-1:0] ras_din;
  logic [WIDTH-1:0] ras_dout;
  logic             ras_empty;
  logic             pred_valid;
  logic             pred_hit;
  logic [WIDTH-1:0] pred_target;
  logic             resolve_err;

  modport master (
    output in_valid, in_pc, in_instr, resolve_valid, resolve_mispredict,
           ras_dout, ras_empty,
    input  in_ready, ras_push, ras_pop, ras_branch, ras_close_valid,
           ras_close_invalid, ras_din, pred_valid, pred_hit, pred_target,
           resolve_err
  );

  modport slave (
    input  in_valid, in_pc, in_instr, resolve_valid, resolve_mispredict,
           ras_dout, ras_empty,
    output in_ready, ras_push, ras_pop, ras_branch, ras_close_valid,
           ras_close_invalid, ras_din, pred_valid, pred_hit, pred_target,
           resolve_err
  );
endinterface
`default_nettype wire

// File: rtl/ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ras_ctrl : decodes calls/returns/branches into RAS controls and      |
// | forms the return prediction. rev 1.0                                 |
// +----------------------------------------------------------------------+
module ras_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MAXBRANCHES = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ras_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAXBRANCHES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [6:0]       C_JAL  = 7'b1101111;
  localparam logic [6:0]       C_JALR = 7'b1100111;
  localparam logic [6:0]       C_BR   = 7'b1100011;

  logic [CNT_W-1:0] count_q, count_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             branch_q, branch_d;
  logic             close_valid_q, close_valid_d;
  logic             close_invalid_q, close_invalid_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_hit_q, pred_hit_d;
  logic [WIDTH-1:0] pred_target_q, pred_target_d;
  logic             err_q, err_d;

  logic       w_ready, w_accept, w_resolve_ok;
  logic [4:0] w_rd, w_rs1;
  logic       w_link_rd, w_link_rs1, w_jal, w_jalr, w_br;
  logic       unused_instr;

  assign w_rd       = bus.in_instr[11:7];
  assign w_rs1      = bus.in_instr[19:15];
  assign w_link_rd  = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_link_rs1 = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_jal      = bus.in_instr[6:0] == C_JAL;
  assign w_jalr     = (bus.in_instr[6:0] == C_JALR) && (bus.in_instr[14:12] == 3'b000);
  assign w_br       = bus.in_instr[6:0] == C_BR;
  assign unused_instr = &{1'b0, bus.in_instr[31:20]};

  // A resolve steals the cycle, so branch-open and branch-close never collide.
  assign w_ready      = rst_n && !bus.resolve_valid && (count_q < C_MAX);
  assign w_accept     = bus.in_valid && w_ready;
  assign w_resolve_ok = bus.resolve_valid && (count_q != '0);

  always_comb begin
    push_d          = w_accept && w_link_rd && (w_jal || w_jalr);
    pop_d           = w_accept && w_jalr && w_link_rs1 && (!w_link_rd || (w_rd != w_rs1));
    branch_d        = w_accept && w_br;
    din_d           = push_d ? bus.in_pc + WIDTH'(4) : '0;
    close_valid_d   = w_resolve_ok && !bus.resolve_mispredict;
    close_invalid_d = w_resolve_ok && bus.resolve_mispredict;
    err_d           = err_q || (bus.resolve_valid && (count_q == '0));

    count_d = count_q;
    if (w_resolve_ok)
      count_d = bus.resolve_mispredict ? '0 : count_q - C_ONE;
    else if (branch_d)
      count_d = count_q + C_ONE;

    // A mispredict flush landing with the prediction kills it.
    pred_valid_d  = pop_q && !close_invalid_d;
    pred_hit_d    = pred_valid_d && !bus.ras_empty;
    pred_target_d = pred_hit_d ? bus.ras_dout : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q         <= '0;
      push_q          <= 1'b0;
      pop_q           <= 1'b0;
      branch_q        <= 1'b0;
      close_valid_q   <= 1'b0;
      close_invalid_q <= 1'b0;
      din_q           <= '0;
      pred_valid_q    <= 1'b0;
      pred_hit_q      <= 1'b0;
      pred_target_q   <= '0;
      err_q           <= 1'b0;
    end else begin
      count_q         <= count_d;
      push_q          <= push_d;
      pop_q           <= pop_d;
      branch_q        <= branch_d;
      close_valid_q   <= close_valid_d;
      close_invalid_q <= close_invalid_d;
      din_q           <= din_d;
      pred_valid_q    <= pred_valid_d;
      pred_hit_q      <= pred_hit_d;
      pred_target_q   <= pred_target_d;
      err_q           <= err_d;
    end
  end

  assign bus.in_ready          = w_ready;
  assign bus.ras_push          = push_q;
  assign bus.ras_pop           = pop_q;
  assign bus.ras_branch        = branch_q;
  assign bus.ras_close_valid   = close_valid_q;
  assign bus.ras_close_invalid = close_invalid_q;
  assign bus.ras_din           = din_q;
  assign bus.pred_valid        = pred_valid_q;
  assign bus.pred_hit          = pred_hit_q;
  assign bus.pred_target       = pred_target_q;
  assign bus.resolve_err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ras_ctrl : directed bench for ras_ctrl. rev 1.0                   |
// +----------------------------------------------------------------------+
module tb_ras_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  localparam logic [31:0] C_CALL   = 32'h008000EF; // jal  x1,+8
  localparam logic [31:0] C_RET    = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] C_CORO   = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] C_SAME   = 32'h000080E7; // jalr x1,0(x1)
  localparam logic [31:0] C_BADF3  = 32'h000090E7; // funct3=1, not a JALR
  localparam logic [31:0] C_JALX0  = 32'h0080006F; // jal  x0,+8
  localparam logic [31:0] C_BEQ    = 32'h00000063;

  ras_ctrl_if #(.WIDTH(32)) bus ();

  ras_ctrl #(.WIDTH(32), .MAXBRANCHES(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, bus.ras_push, bus.ras_pop, bus.ras_branch,
              bus.ras_close_valid, bus.ras_close_invalid}, {27'd0, exp});
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_mispredict = 1'b0;
    bus.ras_dout = '0;
    bus.ras_empty = 1'b1;
    tick();
    tick();
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_err", {31'd0, bus.resolve_err}, 32'd0);
    chk("reset_pred", {31'd0, bus.pred_valid}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("ready_idle", {31'd0, bus.in_ready}, 32'd1);

    // call: push only, return address pc+4
    issue(32'h100, C_CALL);
    chk_ctl("call_ctl", 5'b10000);
    chk("call_din", bus.ras_din, 32'h104);
    tick();
    chk_ctl("call_one_cycle", 5'b00000);

    // return with a populated RAS
    issue(32'h200, C_RET);
    chk_ctl("ret_ctl", 5'b01000);
    bus.ras_empty = 1'b0;
    bus.ras_dout  = 32'h104;
    tick();
    chk("ret_pv", {31'd0, bus.pred_valid}, 32'd1);
    chk("ret_hit", {31'd0, bus.pred_hit}, 32'd1);
    chk("ret_tgt", bus.pred_target, 32'h104);
    chk_ctl("ret_pop_one_cycle", 5'b00000);
    tick();
    chk("ret_pv_one_cycle", {31'd0, bus.pred_valid}, 32'd0);

    // return with an empty RAS: prediction strobes but misses, target zero
    issue(32'h200, C_RET);
    bus.ras_empty = 1'b1;
    tick();
    chk("empty_pv", {31'd0, bus.pred_valid}, 32'd1);
    chk("empty_hit", {31'd0, bus.pred_hit}, 32'd0);
    chk("empty_tgt", bus.pred_target, 32'h0);

    // coroutine and boundary decodes
    issue(32'h300, C_CORO);
    chk_ctl("coro_ctl", 5'b11000);
    chk("coro_din", bus.ras_din, 32'h304);
    issue(32'h400, C_SAME);
    chk_ctl("same_link_ctl", 5'b10000);
    issue(32'h500, C_BADF3);
    chk_ctl("bad_funct3_ctl", 5'b00000);
    issue(32'h600, C_JALX0);
    chk_ctl("jal_x0_ctl", 5'b00000);
    issue(32'hFFFF_FFFC, C_CALL);
    chk("wrap_din", bus.ras_din, 32'h0);

    // fill the branch window
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("ready_before_full", {31'd0, bus.in_ready}, 32'd1);
      issue(32'h1000 + 32'(i * 4), C_BEQ);
      if (i == 0) chk_ctl("br_ctl", 5'b00100);
    end
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk_ctl("full_stall", 5'b00000);
    bus.in_valid = 1'b0;
    chk("err_clean", {31'd0, bus.resolve_err}, 32'd0);

    bus.resolve_valid = 1'b1;
    bus.resolve_mispredict = 1'b0;
    #1;
    chk("resolve_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.resolve_valid = 1'b0;
    #1;
    chk_ctl("close_valid_ctl", 5'b00010);
    chk("ready_after_close", {31'd0, bus.in_ready}, 32'd1);

    // flush the remaining 15, then open 3 and flush with a pending prediction
    bus.resolve_valid = 1'b1;
    bus.resolve_mispredict = 1'b1;
    tick();
    bus.resolve_valid = 1'b0;
    chk_ctl("flush15_ctl", 5'b00001);
    for (int i = 0; i < 3; i++) issue(32'h2000, C_BEQ);
    issue(32'h2100, C_RET);
    bus.ras_empty = 1'b0;
    bus.ras_dout  = 32'hABCD;
    bus.resolve_valid = 1'b1;
    bus.resolve_mispredict = 1'b1;
    tick();
    bus.resolve_valid = 1'b0;
    bus.resolve_mispredict = 1'b0;
    chk_ctl("mispredict_ctl", 5'b00001);
    chk("mispredict_pv_killed", {31'd0, bus.pred_valid}, 32'd0);

    // count is now zero: a resolve must be ignored and flagged
    bus.resolve_valid = 1'b1;
    tick();
    bus.resolve_valid = 1'b0;
    chk_ctl("err_no_close", 5'b00000);
    chk("err_set", {31'd0, bus.resolve_err}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, bus.resolve_err}, 32'd1);

    // reset wins over a simultaneous accept and clears the error
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h100;
    bus.in_instr = C_CALL;
    #1;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("rst_err", {31'd0, bus.resolve_err}, 32'd0);
    chk_ctl("rst_ctl", 5'b00000);
    chk("rst_din", bus.ras_din, 32'h0);
    chk("rst_pred", {29'd0, bus.pred_valid, bus.pred_hit, 1'b0} | bus.pred_target, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
